// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer ALU with an iterative shifter.
// Non-shift operations (and shifts by zero) finish in one cycle; shifts by a
// non-zero amount retire SHIFT_STEP bits per cycle in the SHIFT state.
//
// Handshakes: both sides use strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high. The producer holds valid
// and payload until the transfer; ready never depends on valid of the same
// interface. Only one operation is ever in flight, so in_ready stays low
// while shifting or while an undrained result is stalled.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [3:0]      funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_sel,
    output logic            zero,
    output logic            illegal,
    output logic            o_dbg_state
);

    // Shift-amount width; remaining count fits in SW bits (max XLEN-1).
    localparam int            SW     = $clog2(XLEN);
    localparam logic [SW:0]   STEP_W = (SW+1)'(SHIFT_STEP);

    // Operation codes as seen on alu_sel.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic [3:0]      r_alu_sel;
    logic            r_zero;
    logic            r_illegal;

    logic [XLEN-1:0] r_work;
    logic [SW-1:0]   r_remaining;
    logic [3:0]      r_shift_sel;

    logic [3:0]      w_sel;
    logic [SW-1:0]   w_shamt;
    logic            w_is_shift;
    logic            w_illegal;
    logic            w_start_shift;
    logic            w_accept;
    logic [XLEN-1:0] w_imm_res;

    logic [SW:0]     w_rem_ext;
    logic [SW:0]     w_step;
    logic [SW-1:0]   w_rem_nxt;
    logic            w_shift_done;
    logic [XLEN-1:0] w_shift_res;

    assign w_shamt       = op_b[SW-1:0];
    assign w_accept      = in_valid && in_ready;
    assign w_start_shift = w_is_shift && (w_shamt != '0);

    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign alu_sel     = r_alu_sel;
    assign zero        = r_zero;
    assign illegal     = r_illegal;
    assign o_dbg_state = r_state;

    // Decode alu_op/funct into the operation code.
    always_comb begin
        w_sel = ALU_ADD;
        case (alu_op)
            2'b00:   w_sel = ALU_ADD;
            2'b01:   w_sel = ALU_SUB;
            2'b10:   w_sel = funct;
            default: w_sel = {funct[3] & (funct[2:0] == 3'b101), funct[2:0]};
        endcase
    end

    // Single-cycle result; shift codes pass op_a through (only used for shamt 0).
    always_comb begin
        w_imm_res  = '0;
        w_is_shift = 1'b0;
        w_illegal  = 1'b0;
        case (w_sel)
            ALU_ADD:  w_imm_res = op_a + op_b;
            ALU_SUB:  w_imm_res = op_a - op_b;
            ALU_SLT:  w_imm_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: w_imm_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  w_imm_res = op_a ^ op_b;
            ALU_OR:   w_imm_res = op_a | op_b;
            ALU_AND:  w_imm_res = op_a & op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                w_imm_res  = op_a;
                w_is_shift = 1'b1;
            end
            default: begin
                w_imm_res = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // One shift step: min(SHIFT_STEP, remaining) bits, sign fill for SRA.
    always_comb begin
        w_rem_ext    = {1'b0, r_remaining};
        w_step       = (w_rem_ext > STEP_W) ? STEP_W : w_rem_ext;
        w_rem_nxt    = SW'(w_rem_ext - w_step);
        w_shift_done = (w_rem_ext == w_step);
        case (r_shift_sel)
            ALU_SLL: w_shift_res = r_work << w_step;
            ALU_SRA: w_shift_res = $signed(r_work) >>> w_step;
            default: w_shift_res = r_work >> w_step;
        endcase
    end

    // Next state and in_ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = !r_out_valid || out_ready;
                if (w_accept && w_start_shift) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_shift_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shifter working register and remaining count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= '0;
            r_remaining <= '0;
            r_shift_sel <= ALU_ADD;
        end else if (w_accept && w_start_shift) begin
            r_work      <= op_a;
            r_remaining <= w_shamt;
            r_shift_sel <= w_sel;
        end else if (r_state == S_SHIFT) begin
            r_work      <= w_shift_res;
            r_remaining <= w_rem_nxt;
        end
    end

    // Output registers: load on single-cycle accept or shift completion, clear valid on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_alu_sel   <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !w_start_shift) begin
                r_out_valid <= 1'b1;
                r_result    <= w_imm_res;
                r_alu_sel   <= w_sel;
                r_zero      <= (w_imm_res == '0);
                r_illegal   <= w_illegal;
            end else if ((r_state == S_SHIFT) && w_shift_done) begin
                r_out_valid <= 1'b1;
                r_result    <= w_shift_res;
                r_alu_sel   <= r_shift_sel;
                r_zero      <= (w_shift_res == '0);
                r_illegal   <= 1'b0;
            end
        end
    end

endmodule
